// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-channel bus: serial line in, FIFO read port and status out
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 rx;
  logic                 rx_enable;
  logic                 rd_req;
  logic                 err_clear;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic [CW-1:0]        count;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun_err;
  logic                 break_detect;

  modport master (
    input  rx, rx_enable, rd_req, err_clear,
    output rd_data, rd_valid, count, parity_err, framing_err, overrun_err, break_detect
  );

  modport slave (
    output rx, rx_enable, rd_req, err_clear,
    input  rd_data, rd_valid, count, parity_err, framing_err, overrun_err, break_detect
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with parity/framing/break detection and read FIFO
module uart_rx_fifo #(
  parameter int SYSCLK_RATE = 4,
  parameter int BAUD_RATE   = 1,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int PARITY      = 0,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_rx_fifo_if.master bus
);
  localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int BCW          = $clog2(CLKS_PER_BIT);
  localparam int CW           = $clog2(FIFO_DEPTH + 1);
  localparam int PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PAR    = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAITHI = 3'd5;

  logic [1:0]           sync_q;
  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [BCW-1:0]       cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pbit_q, pbit_d;
  logic                 frm_bad_q, frm_bad_d;
  logic                 push, brk, perr_ev, ferr_ev;
  logic                 bit_tick, par_x, par_bad, is_break;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 perr_q, ferr_q, ovr_q, brk_q;
  logic                 pop, full, do_push, overrun;

  assign rxs      = sync_q[1];
  assign bit_tick = (cnt_q == BCW'(CLKS_PER_BIT - 1));
  assign par_x    = ^{shreg_q, pbit_q};
  assign par_bad  = (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.rx};
  end

  // Frame sequencer: start qualification, bit sampling and completion decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    pbit_d    = pbit_q;
    frm_bad_d = frm_bad_q;
    push      = 1'b0;
    brk       = 1'b0;
    perr_ev   = 1'b0;
    ferr_ev   = 1'b0;
    is_break  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs && bus.rx_enable) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == BCW'(HALF - 1)) begin
          cnt_d     = '0;
          idx_d     = '0;
          pbit_d    = 1'b0;
          frm_bad_d = 1'b0;
          state_d   = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting right leaves it at bit 0 after the last sample
          shreg_d = (shreg_q >> 1) | (DATA_BITS'(rxs) << (DATA_BITS - 1));
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (bit_tick) begin
          cnt_d   = '0;
          pbit_d  = rxs;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d     = '0;
          frm_bad_d = frm_bad_q | ~rxs;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            idx_d    = '0;
            is_break = (shreg_q == '0) && !pbit_q && frm_bad_d;
            if (is_break) begin
              brk     = 1'b1;
              state_d = S_WAITHI;
            end else begin
              push    = 1'b1;
              perr_ev = par_bad;
              ferr_ev = frm_bad_d;
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAITHI: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      pbit_q    <= 1'b0;
      frm_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      pbit_q    <= pbit_d;
      frm_bad_q <= frm_bad_d;
    end
  end

  // A full FIFO still accepts a word when the same edge pops one
  assign pop     = bus.rd_req && (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);
  assign overrun = push && full && !pop;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  // FIFO pointers, occupancy and sticky status; a new error beats a clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(pop);
      perr_q  <= (perr_q & ~bus.err_clear) | perr_ev;
      ferr_q  <= (ferr_q & ~bus.err_clear) | ferr_ev;
      ovr_q   <= (ovr_q  & ~bus.err_clear) | overrun;
      brk_q   <= brk;
    end
  end

  assign bus.rd_data      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.rd_valid     = (count_q != '0);
  assign bus.count        = count_q;
  assign bus.parity_err   = perr_q;
  assign bus.framing_err  = ferr_q;
  assign bus.overrun_err  = ovr_q;
  assign bus.break_detect = brk_q;
endmodule
